// File: rtl/multicycle_alu.sv
// Clocked ALU with single-cycle logic/arith/shift ops plus iterative shift-add multiply
// and (when MULTICYCLE_ALU_DIV_EN is defined) restoring divide behind a start/busy/valid handshake.
module multicycle_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             div_by_zero
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_MUL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_DIV  = 4'b1011;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    localparam int CW = SHW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01
`ifdef MULTICYCLE_ALU_DIV_EN
        ,
        S_DIV  = 2'b10
`endif
    } state_t;

    state_t               state_r;
    logic [CW-1:0]        cnt_r;
    logic [2*WIDTH-1:0]   work_r;
    logic [WIDTH-1:0]     opnd_r;
    logic [WIDTH-1:0]     result_r;
    logic [WIDTH-1:0]     result_hi_r;
    logic                 valid_r;
    logic                 busy_r;
    logic                 dbz_r;

    logic [WIDTH-1:0]     single_lo_s;
    logic [WIDTH-1:0]     single_hi_s;
    logic                 single_dbz_s;
    logic                 slt_s;
    logic                 sltu_s;
    logic                 iter_s;
    logic [WIDTH:0]       mul_sum_s;
    logic [2*WIDTH-1:0]   step_s;
`ifdef MULTICYCLE_ALU_DIV_EN
    logic [WIDTH:0]       div_shift_s;
    logic [WIDTH:0]       div_diff_s;
    logic                 div_iter_s;
`endif

    assign slt_s  = ($signed(a) < $signed(b));
    assign sltu_s = (a < b);

`ifdef MULTICYCLE_ALU_DIV_EN
    assign div_iter_s = (b != {WIDTH{1'b0}});
    assign iter_s     = (state_r == S_MUL) || (state_r == S_DIV);
`else
    assign iter_s     = (state_r == S_MUL);
`endif

    // Single-cycle result selection from the live request operands
    always_comb begin
        single_lo_s  = {WIDTH{1'b0}};
        single_hi_s  = {WIDTH{1'b0}};
        single_dbz_s = 1'b0;
        case (alu_control)
            OP_AND:  single_lo_s = a & b;
            OP_OR:   single_lo_s = a | b;
            OP_ADD:  single_lo_s = a + b;
            OP_SUB:  single_lo_s = a - b;
            OP_NOR:  single_lo_s = ~(a | b);
            OP_XOR:  single_lo_s = a ^ b;
            OP_SLT:  single_lo_s = {{(WIDTH-1){1'b0}}, slt_s};
            OP_SLTU: single_lo_s = {{(WIDTH-1){1'b0}}, sltu_s};
            OP_SLL:  single_lo_s = a << shamt;
            OP_SRL:  single_lo_s = a >> shamt;
            OP_SRA:  single_lo_s = WIDTH'($signed(a) >>> shamt);
            OP_DIV: begin
`ifdef MULTICYCLE_ALU_DIV_EN
                // Only reaches the outputs when b is zero; nonzero divisors iterate.
                single_lo_s  = {WIDTH{1'b1}};
                single_hi_s  = a;
                single_dbz_s = 1'b1;
`else
                single_lo_s  = {WIDTH{1'b0}};
                single_hi_s  = {WIDTH{1'b0}};
                single_dbz_s = 1'b0;
`endif
            end
            default: single_lo_s = a + b;
        endcase
    end

    // One iteration step of the multiplier (or divider) on the internal work register
    always_comb begin
        mul_sum_s = {1'b0, work_r[2*WIDTH-1:WIDTH]}
                  + (work_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
        step_s    = {mul_sum_s, work_r[WIDTH-1:1]};
`ifdef MULTICYCLE_ALU_DIV_EN
        // Work register holds {remainder, dividend/quotient}; a borrow in bit WIDTH restores.
        div_shift_s = {work_r[2*WIDTH-1:WIDTH], work_r[WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, opnd_r};
        if (state_r == S_DIV) begin
            if (!div_diff_s[WIDTH]) begin
                step_s = {div_diff_s[WIDTH-1:0], work_r[WIDTH-2:0], 1'b1};
            end else begin
                step_s = {div_shift_s[WIDTH-1:0], work_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_s = {mul_sum_s, work_r[WIDTH-1:1]};
        end
`endif
    end

    // Control FSM, iteration datapath and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= S_IDLE;
            cnt_r       <= {CW{1'b0}};
            work_r      <= {(2*WIDTH){1'b0}};
            opnd_r      <= {WIDTH{1'b0}};
            result_r    <= {WIDTH{1'b0}};
            result_hi_r <= {WIDTH{1'b0}};
            valid_r     <= 1'b0;
            busy_r      <= 1'b0;
            dbz_r       <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            if (state_r == S_IDLE) begin
                if (start) begin
                    dbz_r <= 1'b0;
                    if (alu_control == OP_MUL) begin
                        state_r <= S_MUL;
                        busy_r  <= 1'b1;
                        cnt_r   <= CNT_FULL;
                        work_r  <= {{WIDTH{1'b0}}, b};
                        opnd_r  <= a;
`ifdef MULTICYCLE_ALU_DIV_EN
                    end else if ((alu_control == OP_DIV) && div_iter_s) begin
                        state_r <= S_DIV;
                        busy_r  <= 1'b1;
                        cnt_r   <= CNT_FULL;
                        work_r  <= {{WIDTH{1'b0}}, a};
                        opnd_r  <= b;
`endif
                    end else begin
                        result_r    <= single_lo_s;
                        result_hi_r <= single_hi_s;
                        dbz_r       <= single_dbz_s;
                        valid_r     <= 1'b1;
                    end
                end
            end else if (iter_s) begin
                work_r <= step_s;
                cnt_r  <= cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    state_r     <= S_IDLE;
                    busy_r      <= 1'b0;
                    result_r    <= step_s[WIDTH-1:0];
                    result_hi_r <= step_s[2*WIDTH-1:WIDTH];
                    dbz_r       <= 1'b0;
                    valid_r     <= 1'b1;
                end
            end else begin
                // Unreachable encoding: fall back to a quiet idle state.
                state_r <= S_IDLE;
                busy_r  <= 1'b0;
                cnt_r   <= {CW{1'b0}};
            end
        end
    end

    assign busy        = busy_r;
    assign valid       = valid_r;
    assign result      = result_r;
    assign result_hi   = result_hi_r;
    assign zero        = (result_r == {WIDTH{1'b0}});
`ifdef MULTICYCLE_ALU_DIV_EN
    assign div_by_zero = dbz_r;
`else
    assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed self-checking bench for multicycle_alu (WIDTH=32).
module tb_multicycle_alu;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_MUL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_DIV  = 4'b1011;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [3:0]  alu_control;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic        busy;
    logic        valid;
    logic [31:0] result;
    logic [31:0] result_hi;
    logic        zero;
    logic        div_by_zero;

    int tests;
    int errors;

    multicycle_alu #(.WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .alu_control(alu_control),
        .a(a), .b(b), .shamt(shamt), .busy(busy), .valid(valid), .result(result),
        .result_hi(result_hi), .zero(zero), .div_by_zero(div_by_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Present a request for exactly one edge; returns 1ns after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                         input logic [4:0] sh);
        start = 1'b1; alu_control = op; a = av; b = bv; shamt = sh;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; alu_control = 4'b0000; a = 32'h0; b = 32'h0; shamt = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
        tests++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
        tests++; if (result_hi !== 32'h0) begin errors++; $display("FAIL reset_result_hi: got %h want 0", result_hi); end
        tests++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero: got %b want 1", zero); end
        tests++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
        reset_n = 1'b1;
    endtask

    task automatic test_single_ops();
        issue(OP_SUB, 32'd5, 32'd7, 5'd0);
        tests++; if (valid !== 1'b1) begin errors++; $display("FAIL sub_valid: got %b want 1", valid); end
        tests++; if (result !== 32'hFFFFFFFE) begin errors++; $display("FAIL sub_result: got %h want fffffffe", result); end
        tests++; if (zero !== 1'b0) begin errors++; $display("FAIL sub_zero: got %b want 0", zero); end
        tests++; if (result_hi !== 32'h0) begin errors++; $display("FAIL sub_result_hi: got %h want 0", result_hi); end
        @(posedge clk); #1;
        tests++; if (valid !== 1'b0) begin errors++; $display("FAIL sub_valid_drop: got %b want 0", valid); end
        issue(OP_SLT, 32'hFFFFFFFF, 32'd1, 5'd0);
        tests++; if (result !== 32'd1) begin errors++; $display("FAIL slt: got %h want 1", result); end
        issue(OP_SLTU, 32'hFFFFFFFF, 32'd1, 5'd0);
        tests++; if (result !== 32'd0) begin errors++; $display("FAIL sltu: got %h want 0", result); end
        tests++; if (zero !== 1'b1) begin errors++; $display("FAIL sltu_zero: got %b want 1", zero); end
        issue(OP_SRA, 32'h80000000, 32'd0, 5'd4);
        tests++; if (result !== 32'hF8000000) begin errors++; $display("FAIL sra: got %h want f8000000", result); end
        issue(OP_SRL, 32'h80000000, 32'd0, 5'd4);
        tests++; if (result !== 32'h08000000) begin errors++; $display("FAIL srl: got %h want 08000000", result); end
        issue(OP_SLL, 32'd1, 32'd0, 5'd31);
        tests++; if (result !== 32'h80000000) begin errors++; $display("FAIL sll: got %h want 80000000", result); end
        issue(OP_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0);
        tests++; if (result !== 32'h00F000F0) begin errors++; $display("FAIL and: got %h want 00f000f0", result); end
        issue(OP_OR, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0);
        tests++; if (result !== 32'hFFF0FFF0) begin errors++; $display("FAIL or: got %h want fff0fff0", result); end
        issue(OP_XOR, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0);
        tests++; if (result !== 32'hFF00FF00) begin errors++; $display("FAIL xor: got %h want ff00ff00", result); end
        issue(OP_NOR, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0);
        tests++; if (result !== 32'h000F000F) begin errors++; $display("FAIL nor: got %h want 000f000f", result); end
        issue(OP_ADD, 32'hFFFFFFFF, 32'd1, 5'd0);
        tests++; if (result !== 32'h0 || zero !== 1'b1) begin errors++; $display("FAIL add_wrap: got %h zero %b want 0 zero 1", result, zero); end
        issue(4'b1111, 32'd3, 32'd4, 5'd0);
        tests++; if (result !== 32'd7) begin errors++; $display("FAIL default_add: got %h want 7", result); end
    endtask

    task automatic test_mul();
        int n;
        int busy_cnt;
        int changed;
        issue(OP_ADD, 32'd40, 32'd2, 5'd0);
        issue(OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0);
        n = 0; busy_cnt = 0; changed = 0;
        while (!valid && n < 100) begin
            if (busy) busy_cnt++;
            if (result !== 32'd42) changed++;
            @(posedge clk); #1;
            n++;
        end
        tests++; if (n !== 32) begin errors++; $display("FAIL mul_latency: got %0d want 32", n); end
        tests++; if (busy_cnt !== 32) begin errors++; $display("FAIL mul_busy_cycles: got %0d want 32", busy_cnt); end
        tests++; if (changed !== 0) begin errors++; $display("FAIL mul_result_stable: got %0d changes want 0", changed); end
        tests++; if (result_hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL mul_hi: got %h want fffffffe", result_hi); end
        tests++; if (result !== 32'h00000001) begin errors++; $display("FAIL mul_lo: got %h want 00000001", result); end
        tests++; if (busy !== 1'b0) begin errors++; $display("FAIL mul_busy_done: got %b want 0", busy); end
        @(posedge clk); #1;
        tests++; if (valid !== 1'b0) begin errors++; $display("FAIL mul_valid_once: got %b want 0", valid); end
        issue(OP_MUL, 32'h80000000, 32'd2, 5'd0);
        n = 0;
        while (!valid && n < 100) begin @(posedge clk); #1; n++; end
        tests++; if (result_hi !== 32'd1 || result !== 32'd0 || zero !== 1'b1) begin
            errors++; $display("FAIL mul_carry: got %h_%h zero %b want 00000001_00000000 zero 1", result_hi, result, zero); end
    endtask

    task automatic test_div();
        int n;
`ifdef MULTICYCLE_ALU_DIV_EN
        issue(OP_DIV, 32'd100, 32'd7, 5'd0);
        n = 0;
        while (!valid && n < 100) begin
            if (n == 2) begin
                start = 1'b1; alu_control = OP_ADD; a = 32'd1; b = 32'd1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        tests++; if (n !== 32) begin errors++; $display("FAIL div_latency: got %0d want 32", n); end
        tests++; if (result !== 32'd14) begin errors++; $display("FAIL div_quotient: got %h want 0000000e", result); end
        tests++; if (result_hi !== 32'd2) begin errors++; $display("FAIL div_remainder: got %h want 2", result_hi); end
        tests++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL div_dbz: got %b want 0", div_by_zero); end
        @(posedge clk); #1;
        tests++; if (valid !== 1'b0 || result !== 32'd14) begin errors++; $display("FAIL div_ignored_start: valid %b result %h want 0 0000000e", valid, result); end
        issue(OP_DIV, 32'd100, 32'd0, 5'd0);
        tests++; if (valid !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL dbz_latency: valid %b busy %b want 1 0", valid, busy); end
        tests++; if (result !== 32'hFFFFFFFF) begin errors++; $display("FAIL dbz_result: got %h want ffffffff", result); end
        tests++; if (result_hi !== 32'd100) begin errors++; $display("FAIL dbz_result_hi: got %h want 64", result_hi); end
        tests++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_flag: got %b want 1", div_by_zero); end
        issue(OP_ADD, 32'd1, 32'd1, 5'd0);
        tests++; if (div_by_zero !== 1'b0 || result !== 32'd2) begin errors++; $display("FAIL dbz_clear: dbz %b result %h want 0 2", div_by_zero, result); end
`else
        issue(OP_DIV, 32'd100, 32'd7, 5'd0);
        n = 0;
        tests++; if (valid !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL nodiv_latency: valid %b busy %b want 1 0", valid, busy); end
        tests++; if (result !== 32'd0 || result_hi !== 32'd0) begin errors++; $display("FAIL nodiv_result: got %h_%h want 0_0", result_hi, result); end
        tests++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL nodiv_dbz: got %b want 0", div_by_zero); end
        issue(OP_DIV, 32'd100, 32'd0, 5'd0);
        tests++; if (div_by_zero !== 1'b0 || result !== 32'd0) begin errors++; $display("FAIL nodiv_b0: dbz %b result %h want 0 0", div_by_zero, result); end
        issue(OP_ADD, 32'd1, 32'd1, 5'd0);
        tests++; if (result !== 32'd2) begin errors++; $display("FAIL nodiv_add: got %h want 2", result); end
`endif
    endtask

    task automatic test_back_to_back();
        int n;
        start = 1'b1; alu_control = OP_MUL; a = 32'd3; b = 32'd4; shamt = 5'd0;
        @(posedge clk); #1;
        alu_control = OP_ADD; a = 32'd2; b = 32'd2;
        n = 0;
        while (!valid && n < 100) begin @(posedge clk); #1; n++; end
        tests++; if (result !== 32'd12 || n !== 32) begin errors++; $display("FAIL b2b_mul: result %h after %0d want 0000000c after 32", result, n); end
        @(posedge clk); #1;
        start = 1'b0;
        tests++; if (valid !== 1'b1 || result !== 32'd4) begin errors++; $display("FAIL b2b_add: valid %b result %h want 1 4", valid, result); end
        @(posedge clk); #1;
        tests++; if (valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_drop: got %b want 0", valid); end
    endtask

    task automatic test_reset_mid_mul();
        int pulses;
        issue(OP_ADD, 32'd5, 32'd6, 5'd0);
        issue(OP_MUL, 32'd7, 32'd9, 5'd0);
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        tests++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        tests++; if (result !== 32'h0 || zero !== 1'b1) begin errors++; $display("FAIL rst_mid_result: got %h zero %b want 0 1", result, zero); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (valid) pulses++;
        end
        tests++; if (pulses !== 0) begin errors++; $display("FAIL rst_mid_no_valid: got %0d pulses want 0", pulses); end
        tests++; if (result !== 32'h0 || zero !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_mid_final: result %h zero %b busy %b want 0 1 0", result, zero, busy); end
    endtask

    initial begin
        tests = 0;
        errors = 0;
        test_reset();
        @(posedge clk); #1;
        test_single_ops();
        test_mul();
        test_div();
        test_back_to_back();
        test_reset_mid_mul();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
